// File: rtl/cpu_mdu_pkg.sv
// cpu_mdu_pkg -- shared types for the multiply/divide unit.
//   mdu_op_t    : 3-bit operation code driven on mult_div_unit.op
//                 (code 7 is not listed and is treated like NONE)
//   mdu_state_t : IDLE / RUN sequencing state
//   helpers     : operation class decoding used by the top level
package cpu_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  function automatic logic op_is_mult(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith -- combinational datapath of the multiply/divide unit.
// Computes the full 2*WIDTH product, or quotient/remainder, from the
// operands latched by the top level.
//   a, b       : latched operands (a = dividend / multiplicand)
//   is_signed  : treat operands as two's complement
//   is_div     : select divide result instead of product
//   hi_res     : product upper half / remainder
//   lo_res     : product lower half / quotient
// Configuration macro MDU_DIV_EN: when undefined no divider is built and
// the outputs always carry the product.
module mdu_arith
  import cpu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             is_div,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;

  // Sign/zero extend to 2*WIDTH so one unsigned multiply, truncated to
  // 2*WIDTH bits, yields the correct signed or unsigned product.
  always_comb begin
    a_ext = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod  = a_ext * b_ext;
  end

`ifdef MDU_DIV_EN
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  // Divide magnitudes, then restore signs: quotient truncates toward zero
  // and the remainder takes the dividend's sign. For most-negative / -1
  // the magnitude quotient is 2**(WIDTH-1), whose bit pattern is exactly
  // the most-negative value, and the remainder is 0 -- no special case.
  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    q_mag = '0;
    r_mag = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    if (!is_div) begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end else if (b == '0) begin
      hi_res = a;
      lo_res = '1;
    end else begin
      hi_res = a_neg ? -r_mag : r_mag;
      lo_res = (a_neg ^ b_neg) ? -q_mag : q_mag;
    end
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div;

  always_comb begin
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
  end
`endif

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit -- multi-cycle multiply/divide unit with HI/LO registers.
// Configuration macro MDU_DIV_EN enables DIV/DIVU; otherwise they are
// ignored like NONE.
// Ports:
//   clk, reset (async, active low)
//   start/op/src_a/src_b : issue an operation (op codes in cpu_mdu_pkg)
//   cancel               : abort the in-flight operation
//   busy                 : multi-cycle operation in flight
//   done                 : one-cycle pulse when a new HI/LO result is visible
//   hi, lo               : architectural HI/LO registers
//   stall_req            : busy, or a mult/div op being presented now
// Handshake: start is a single-cycle request sampled on the rising edge.
// A mult/div request is taken only when idle or in the final busy cycle
// (and not together with cancel); requests at other times are dropped,
// so the issuing stage must hold off while stall_req is high.
// The sequencing state is visible as state_q (IDLE/RUN) for checkers.
module mult_div_unit
  import cpu_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall_req
);

`ifdef MDU_DIV_EN
  localparam int MAX_LAT = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
`else
  localparam int MAX_LAT = MULT_CYCLES;
  localparam int unused_div_cycles = DIV_CYCLES;
`endif
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             op_md;
  logic             finish;
  logic             accept;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .a         (a_q),
    .b         (b_q),
    .is_signed (signed_q),
    .is_div    (div_q),
    .hi_res    (res_hi),
    .lo_res    (res_lo)
  );

  always_comb begin
    op_md = op_is_mult(op);
`ifdef MDU_DIV_EN
    op_md = op_md | op_is_div(op);
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    div_d    = div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    // cancel wins over completion and over a same-cycle start.
    finish = (state_q == ST_RUN) && !cancel && (cnt_q == CNT_W'(1));
    accept = start && op_md && ((state_q == ST_IDLE) || finish);

    case (state_q)
      ST_IDLE: begin
        if (start && (op == MDU_MTHI)) hi_d = src_a;
        if (start && (op == MDU_MTLO)) lo_d = src_a;
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (finish) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Taking a new op in the completion cycle keeps busy high throughout.
    if (accept) begin
      state_d  = ST_RUN;
      a_d      = src_a;
      b_d      = src_b;
      signed_d = op_is_signed(op);
      div_d    = op_is_div(op);
      cnt_d    = CNT_W'(MULT_CYCLES);
`ifdef MDU_DIV_EN
      if (op_is_div(op)) cnt_d = CNT_W'(DIV_CYCLES);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      div_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      div_q    <= div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  // Gated by reset so the stall request is low throughout reset.
  assign stall_req = reset & (busy | (start & op_md));

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit -- self-checking bench for mult_div_unit.
// Directed scenarios followed by randomized operations checked against a
// behavioural model using plain 64-bit integer arithmetic. Division cases
// are exercised when MDU_DIV_EN is defined; otherwise DIV/DIVU must be
// ignored.
module tb_mult_div_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic         start  = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   op     = 3'd0;
  logic [W-1:0] src_a  = '0;
  logic [W-1:0] src_b  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         stall_req;

  int total = 0;
  int bad   = 0;

  // Scoreboard: expected {hi,lo} of outstanding mult/div operations.
  logic [2*W-1:0] exp_q[$];
  // Architectural HI/LO as the model believes them to be.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .stall_req (stall_req)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    res = '0;
    case (o)
      3'd1: begin
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'(sa * sb);
      end
      3'd2: res = {32'b0, a} * {32'b0, b};
      3'd3, 3'd4: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          sa  = (o == 3'd3) ? longint'($signed(a)) : longint'({32'b0, a});
          sb  = (o == 3'd3) ? longint'($signed(b)) : longint'({32'b0, b});
          q   = sa / sb;
          r   = sa % sb;
          res = {32'(r), 32'(q)};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div op and follow it to completion.
  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int n, input string tag);
    int   cyc;
    logic held_ok;
    logic done_early;
    exp_q.push_back(ref_md(o, a, b));
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1;
    check({tag, "_stall"}, 64'(stall_req), 64'd1);
    step();
    start = 1'b0; op = 3'd0;
    cyc = 0; held_ok = 1'b1; done_early = 1'b0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if ({hi, lo} !== {m_hi, m_lo}) held_ok = 1'b0;
      if (done !== 1'b0) done_early = 1'b1;
      step();
    end
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
    check({tag, "_held"}, {63'd0, held_ok}, 64'd1);
    check({tag, "_no_early_done"}, {63'd0, done_early}, 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    {m_hi, m_lo} = exp_q.pop_front();
    check({tag, "_result"}, {hi, lo}, {m_hi, m_lo});
    step();
    check({tag, "_done_drop"}, 64'(done), 64'd0);
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] a, input string tag);
    op = o; src_a = a; start = 1'b1;
    step();
    start = 1'b0; op = 3'd0;
    if (o == 3'd5) m_hi = a;
    else m_lo = a;
    check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    check({tag, "_busy_done"}, {62'd0, busy, done}, 64'd0);
  endtask

  // Watch n cycles for any busy/done activity.
  task automatic quiet(input int n, input string tag);
    logic act;
    act = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) act = 1'b1;
      step();
    end
    check({tag, "_quiet"}, {63'd0, act}, 64'd0);
    check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0]    busy_v;
    logic [10:0]    done_v;
    logic [63:0]    r1;
    logic [63:0]    r2;
    logic [2:0]     ops[$];
    logic [2:0]     o;
    logic [31:0]    a;
    logic [31:0]    b;
    int             k;

    // Reset state, including stall_req held low under reset.
    #2;
    check("reset_outs", {61'd0, busy, done, stall_req}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    start = 1'b1; op = 3'd1;
    #1;
    check("reset_stall_gated", 64'(stall_req), 64'd0);
    start = 1'b0; op = 3'd0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Multiply directed cases.
    run_md(3'd1, 32'hFFFF_FFFF, 32'h2, MC, "mult");
    check("mult_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_md(3'd2, 32'hFFFF_FFFF, 32'h2, MC, "multu");
    check("multu_lit", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

`ifdef MDU_DIV_EN
    run_md(3'd3, 32'hFFFF_FFF9, 32'h2, DC, "div_neg");
    check("div_neg_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(3'd4, 32'h7, 32'h0, DC, "divu_zero");
    check("divu_zero_lit", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, "div_ovf");
    check("div_ovf_lit", {hi, lo}, 64'h0000_0000_8000_0000);
`else
    for (int i = 3; i <= 4; i++) begin
      op = 3'(i); src_a = 32'd7; src_b = 32'd2; start = 1'b1;
      #1;
      check("nodiv_stall", 64'(stall_req), 64'd0);
      step();
      start = 1'b0; op = 3'd0;
      check("nodiv_busy", 64'(busy), 64'd0);
      quiet(3, "nodiv");
    end
`endif

    // Moves while idle, and the unused code 7.
    move_to(3'd5, 32'h1234, "mthi");
    check("mthi_lit", 64'(hi), 64'h1234);
    move_to(3'd6, 32'h5678_9ABC, "mtlo");
    op = 3'd7; src_a = 32'hDEAD; start = 1'b1;
    step();
    start = 1'b0; op = 3'd0;
    quiet(3, "op7");

    // MTLO during busy is dropped; lo ends as the product.
    op = 3'd1; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
    step();
    op = 3'd6; src_a = 32'hDEAD_BEEF;
    step();
    start = 1'b0; op = 3'd0;
    k = 0;
    while (busy === 1'b1 && k < 50) begin k++; step(); end
    {m_hi, m_lo} = ref_md(3'd1, 32'd3, 32'd5);
    check("mtlo_busy_done", 64'(done), 64'd1);
    check("mtlo_busy_result", {hi, lo}, 64'd15);
    step();

    // Cancel on cycle 3 of a multiply.
    op = 3'd1; src_a = 32'h11; src_b = 32'h22; start = 1'b1;
    step();
    start = 1'b0; op = 3'd0;
    step();
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    quiet(8, "cancel");

    // Cancel and start in the same cycle: op aborted, start dropped.
    op = 3'd1; src_a = 32'h33; src_b = 32'h44; start = 1'b1;
    step();
    op = 3'd2; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0; op = 3'd0;
    check("cancel_start_busy", 64'(busy), 64'd0);
    quiet(12, "cancel_start");

    // Cancel while idle does nothing.
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    quiet(2, "cancel_idle");

    // Back-to-back multiplies: second start in the final busy cycle.
    op = 3'd1; src_a = 32'd100; src_b = 32'hFFFF_FFFD; start = 1'b1;
    step();
    start = 1'b0; op = 3'd0;
    busy_v = '0; done_v = '0; r1 = '0; r2 = '0;
    busy_v[0] = busy; done_v[0] = done;
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) begin op = 3'd2; src_a = 32'h8000_0001; src_b = 32'd6; start = 1'b1; end
      step();
      if (i == 5) begin start = 1'b0; op = 3'd0; r1 = {hi, lo}; end
      if (i == 10) r2 = {hi, lo};
      busy_v[i] = busy; done_v[i] = done;
    end
    check("b2b_busy_mask", 64'(busy_v), 64'b011_1111_1111);
    check("b2b_done_mask", 64'(done_v), 64'b100_0010_0000);
    check("b2b_res1", r1, ref_md(3'd1, 32'd100, 32'hFFFF_FFFD));
    {m_hi, m_lo} = ref_md(3'd2, 32'h8000_0001, 32'd6);
    check("b2b_res2", r2, {m_hi, m_lo});
    step();

    // Randomized operations against the model.
    ops = '{3'd1, 3'd2, 3'd5, 3'd6};
`ifdef MDU_DIV_EN
    ops.push_back(3'd3);
    ops.push_back(3'd4);
`endif
    for (int i = 0; i < 16; i++) begin
      o = ops[$urandom_range(ops.size() - 1)];
      a = $urandom();
      b = $urandom();
      case ($urandom_range(5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'(1 + $urandom_range(15));
        default: ;
      endcase
      if (o == 3'd5 || o == 3'd6) move_to(o, a, "rnd_mv");
      else run_md(o, a, b, (o == 3'd3 || o == 3'd4) ? DC : MC, "rnd_md");
    end

    // Asynchronous reset in the middle of an operation.
    move_to(3'd5, 32'hCAFE_F00D, "pre_rst");
`ifdef MDU_DIV_EN
    op = 3'd3;
`else
    op = 3'd1;
`endif
    src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
    step();
    start = 1'b0; op = 3'd0;
    step();
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_outs", {61'd0, busy, done, stall_req}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    step();
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    quiet(14, "rst_discard");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, multiply latency in cycles (>=1).
- DIV_CYCLES, 10, divide latency in cycles (>=1).

REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, accept op this cycle.
- op, in, 3, operation (mdu_op_t).
- src_a, in, WIDTH, rs operand / mthi-mtlo data.
- src_b, in, WIDTH, rt operand.
- cancel, in, 1, abort in-flight op (exception flush).
- busy, out, 1, multi-cycle op in flight.
- done, out, 1, one-cycle pulse when new HI/LO visible.
- hi, out, WIDTH, HI register.
- lo, out, WIDTH, LO register.
- stall_req, out, 1, busy | (start & op is mult/div class), for the stall unit.

Function
REQ-003 Ops SHALL be NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; codes 7 and NONE SHALL be ignored.
REQ-004 MULT/MULTU with start=1 and busy=0 SHALL latch the operands at edge E0, set busy for exactly MULT_CYCLES cycles, and write {hi,lo} = 2*WIDTH product (signed / unsigned) at edge E0+MULT_CYCLES.
REQ-005 DIV/DIVU SHALL behave likewise with DIV_CYCLES: lo = quotient, hi = remainder, truncation toward zero, remainder sign = dividend sign.
REQ-006 Divide by zero SHALL give lo = all ones and hi = dividend.
REQ-007 Signed overflow (most negative / -1) SHALL give lo = most negative and hi = 0.
REQ-008 At the completing edge busy SHALL fall and done SHALL rise for one cycle, with the new hi/lo visible in the same cycle.
REQ-009 MTHI/MTLO with busy=0 SHALL write src_a into hi/lo at the next edge with zero latency, and SHALL NOT assert busy or done.
REQ-010 Any start while busy=1 SHALL be ignored; busy, the counter and the latched operands SHALL be unchanged.
REQ-011 cancel=1 while busy SHALL clear busy at the next edge, leave hi/lo at their pre-op values and suppress done.
REQ-012 cancel and start in the same cycle SHALL be resolved cancel-first: the in-flight op is aborted and the new start is not accepted.
REQ-013 cancel while idle SHALL have no effect.
REQ-014 A start in the cycle busy falls SHALL be accepted; busy SHALL stay high continuously.
REQ-015 hi/lo SHALL be readable combinationally at all times; during busy they SHALL hold their pre-op values.
REQ-016 State SHALL be IDLE or RUN; the down-counter SHALL be $clog2(max latency + 1) bits wide.
- IDLE to RUN on an accepted mult/div op.
- RUN to IDLE when the counter reaches 1 (completion) or on cancel.

Reset
REQ-017 While reset=0 (asynchronous assertion): hi=0, lo=0, busy=0, done=0, stall_req=0, state=IDLE, counter=0; reset mid-operation SHALL discard the op.
REQ-018 Reset release SHALL be sampled on the clk edge; first start accepted at the first edge with reset=1.

Configuration
REQ-019 Macro MDU_DIV_EN SHALL gate division support.
- Defined: DIV/DIVU per REQ-005 to REQ-007.
- Undefined: DIV/DIVU SHALL be treated as NONE (no busy, no stall_req, hi/lo unchanged); no divider logic synthesised; DIV_CYCLES unused.

Structure
REQ-020 Package cpu_mdu_pkg SHALL hold mdu_op_t, the op code constants and the state enum.
REQ-021 Sub-module mdu_arith SHALL compute the combinational 2*WIDTH product / quotient-remainder from the latched operands, including REQ-006 and REQ-007.

Verification
REQ-022 The bench SHALL cover these directed scenarios (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10 unless noted):
- MULT 0xFFFFFFFF x 0x00000002 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done for 1 cycle. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- MTHI 0x1234 while idle -> hi=0x1234 next cycle, busy=0. MTLO issued during busy -> ignored; lo = op result.
- MULT started, cancel on cycle 3 -> busy=0 next cycle, no done, hi/lo unchanged; cancel+start same cycle -> start dropped.
- Back-to-back MULT, second start in the done cycle -> busy continuous for 10 cycles, two done pulses 5 cycles apart.
- reset=0 asserted mid-DIV -> outputs clear immediately (no clock edge needed); with MDU_DIV_EN undefined, DIV start -> busy and stall_req stay 0.
